stream_header_gen: RTL and testbench

STREAM_HEADER_GEN -- requirements
Module: stream_header_gen

---
 rtl/stream_header_gen.sv | 184 ++++++++++++++++++
 tb/tb_stream_header_gen.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_header_gen.sv
// stream_header_gen: forwards framed pixel streams and appends a header block after each frame; STREAM_HEADER_TIMESTAMP_EN adds frame-start timestamps
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 8
`endif
`ifndef DTYPE_FRAME_START
`define DTYPE_FRAME_START 8'h01
`endif
`ifndef DTYPE_FRAME_END
`define DTYPE_FRAME_END 8'h02
`endif
`ifndef DTYPE_HEADER_START
`define DTYPE_HEADER_START 8'h04
`endif
`ifndef DTYPE_HEADER
`define DTYPE_HEADER 8'h08
`endif
`ifndef DTYPE_HEADER_END
`define DTYPE_HEADER_END 8'h10
`endif
`ifndef DTYPE_PIXEL_MASK
`define DTYPE_PIXEL_MASK 8'hC0
`endif

module stream_header_gen #(
    parameter int HEADER_WORDS = 16,
    parameter int DATA_WIDTH   = 16
) (
    input  logic                    clk,
    input  logic                    resetb,
    input  logic                    enable,
    input  logic                    dvi,
    input  logic [`DTYPE_WIDTH-1:0] dtypei,
    input  logic [DATA_WIDTH-1:0]   datai,
    output logic                    dvo,
    output logic [`DTYPE_WIDTH-1:0] dtypeo,
    output logic [DATA_WIDTH-1:0]   datao,
    output logic                    busy,
    output logic [15:0]             dropped_count
);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] FRAME     = 3'd1;
    localparam logic [2:0] HDR_START = 3'd2;
    localparam logic [2:0] HDR_DATA  = 3'd3;
    localparam logic [2:0] HDR_END   = 3'd4;

    logic [2:0]              state_q, state_d;
    logic                    enable_q;
    logic [5:0]              word_q, word_d;
    logic [31:0]             frame_count_q, frame_count_d;
    logic [31:0]             pixel_count_q, pixel_count_d;
    logic [31:0]             stamp;
    logic [15:0]             dropped_count_q, dropped_count_d;
    logic [15:0]             word_val;
    logic                    dvo_q, dvo_d;
    logic [`DTYPE_WIDTH-1:0] dtypeo_q, dtypeo_d;
    logic [DATA_WIDTH-1:0]   datao_q, datao_d;
    logic                    is_start, is_end, is_pixel, in_hdr, accept;

    assign is_start = dvi && dtypei == `DTYPE_FRAME_START;
    assign is_end   = dvi && dtypei == `DTYPE_FRAME_END;
    assign is_pixel = dvi && |(dtypei & `DTYPE_PIXEL_MASK);
    assign in_hdr   = state_q == HDR_START || state_q == HDR_DATA || state_q == HDR_END;
    assign accept   = enable && is_start && (state_q == IDLE || state_q == FRAME);

`ifdef STREAM_HEADER_TIMESTAMP_EN
    logic [31:0] tick_q, tick_d, stamp_q, stamp_d;
    always_comb begin
        tick_d  = tick_q + 32'd1;
        stamp_d = accept ? tick_q : stamp_q;
    end
    always_ff @(posedge clk) begin
        if (!resetb) begin
            tick_q  <= '0;
            stamp_q <= '0;
        end else begin
            tick_q  <= tick_d;
            stamp_q <= stamp_d;
        end
    end
    assign stamp = stamp_q;
`else
    assign stamp = '0;
`endif

    assign word_val = word_q == 6'd0 ? 16'hA5C3 :
                      word_q == 6'd1 ? frame_count_q[15:0] :
                      word_q == 6'd2 ? frame_count_q[31:16] :
                      word_q == 6'd3 ? pixel_count_q[15:0] :
                      word_q == 6'd4 ? pixel_count_q[31:16] :
                      word_q == 6'd5 ? stamp[15:0] :
                      word_q == 6'd6 ? stamp[31:16] :
                      word_q == 6'd7 ? dropped_count_q : 16'h0000;

    always_comb begin
        state_d         = state_q;
        word_d          = word_q;
        frame_count_d   = frame_count_q;
        pixel_count_d   = pixel_count_q;
        dropped_count_d = dropped_count_q;
        dvo_d           = 1'b0;
        dtypeo_d        = '0;
        datao_d         = '0;
        if (enable && !enable_q) begin
            frame_count_d   = '0;
            pixel_count_d   = '0;
            dropped_count_d = '0;
        end
        if (enable && in_hdr && is_start && dropped_count_q != 16'hFFFF)
            dropped_count_d = dropped_count_q + 16'd1;
        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_d       = FRAME;
                        dvo_d         = 1'b1;
                        dtypeo_d      = dtypei;
                        datao_d       = datai;
                        pixel_count_d = '0;
                    end
                end
                FRAME: begin
                    dvo_d         = dvi;
                    dtypeo_d      = dvi ? dtypei : '0;
                    datao_d       = dvi ? datai : '0;
                    pixel_count_d = accept ? '0 :
                                    (is_pixel && pixel_count_q != '1) ? pixel_count_q + 32'd1 : pixel_count_q;
                    state_d       = is_end ? HDR_START : FRAME;
                end
                HDR_START: begin
                    dvo_d    = 1'b1;
                    dtypeo_d = `DTYPE_HEADER_START;
                    word_d   = '0;
                    state_d  = HDR_DATA;
                end
                HDR_DATA: begin
                    dvo_d    = 1'b1;
                    dtypeo_d = `DTYPE_HEADER;
                    datao_d  = word_val;
                    word_d   = word_q + 6'd1;
                    state_d  = word_q == 6'(HEADER_WORDS - 1) ? HDR_END : HDR_DATA;
                end
                HDR_END: begin
                    dvo_d         = 1'b1;
                    dtypeo_d      = `DTYPE_HEADER_END;
                    frame_count_d = frame_count_q + 32'd1;
                    state_d       = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            state_q         <= IDLE;
            enable_q        <= 1'b0;
            word_q          <= '0;
            frame_count_q   <= '0;
            pixel_count_q   <= '0;
            dropped_count_q <= '0;
            dvo_q           <= 1'b0;
            dtypeo_q        <= '0;
            datao_q         <= '0;
        end else begin
            state_q         <= state_d;
            enable_q        <= enable;
            word_q          <= word_d;
            frame_count_q   <= frame_count_d;
            pixel_count_q   <= pixel_count_d;
            dropped_count_q <= dropped_count_d;
            dvo_q           <= dvo_d;
            dtypeo_q        <= dtypeo_d;
            datao_q         <= datao_d;
        end
    end

    assign dvo           = dvo_q;
    assign dtypeo        = dtypeo_q;
    assign datao         = datao_q;
    assign busy          = state_q != IDLE;
    assign dropped_count = dropped_count_q;
endmodule

// File: tb/tb_stream_header_gen.sv
// tb_stream_header_gen: randomized and directed stimulus checked against a frame-level reference model
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 8
`endif
`ifndef DTYPE_FRAME_START
`define DTYPE_FRAME_START 8'h01
`endif
`ifndef DTYPE_FRAME_END
`define DTYPE_FRAME_END 8'h02
`endif
`ifndef DTYPE_HEADER_START
`define DTYPE_HEADER_START 8'h04
`endif
`ifndef DTYPE_HEADER
`define DTYPE_HEADER 8'h08
`endif
`ifndef DTYPE_HEADER_END
`define DTYPE_HEADER_END 8'h10
`endif
`ifndef DTYPE_PIXEL_MASK
`define DTYPE_PIXEL_MASK 8'hC0
`endif

module tb_stream_header_gen;
    localparam int HW = 16;
    localparam logic [7:0] FS = `DTYPE_FRAME_START;
    localparam logic [7:0] FE = `DTYPE_FRAME_END;
    localparam logic [7:0] HS = `DTYPE_HEADER_START;
    localparam logic [7:0] HD = `DTYPE_HEADER;
    localparam logic [7:0] HE = `DTYPE_HEADER_END;
    localparam logic [7:0] PM = `DTYPE_PIXEL_MASK;

    logic        clk = 1'b0, resetb = 1'b0, enable = 1'b0, dvi = 1'b0;
    logic [7:0]  dtypei = '0;
    logic [15:0] datai = '0;
    logic        dvo, busy;
    logic [7:0]  dtypeo;
    logic [15:0] datao, dropped_count;

    int          n_checks = 0, n_errors = 0;
    bit          pix_override = 1'b0;
    longint      cyc = 0, hdr_base = 0;
    bit          m_en_prev = 1'b0, m_in_frame = 1'b0, m_in_hdr = 1'b0;
    logic [31:0] m_fc = '0, m_pix = '0, m_ts = '0, m_stamp = '0;
    logic [15:0] m_drop = '0;
    bit          e_dvo, e_busy;
    logic [7:0]  e_dtype;
    logic [15:0] e_data;
    logic [15:0] hdr_obs [HW];
    int          hdr_idx = 0, hdr_cnt = 0, base = 0;

    stream_header_gen #(.HEADER_WORDS(HW), .DATA_WIDTH(16)) dut (
        .clk(clk), .resetb(resetb), .enable(enable), .dvi(dvi), .dtypei(dtypei), .datai(datai),
        .dvo(dvo), .dtypeo(dtypeo), .datao(datao), .busy(busy), .dropped_count(dropped_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] hdr_word(input int i);
        logic [31:0] st;
`ifdef STREAM_HEADER_TIMESTAMP_EN
        st = m_stamp;
`else
        st = '0;
`endif
        case (i)
            0: return 16'hA5C3;
            1: return m_fc[15:0];
            2: return m_fc[31:16];
            3: return m_pix[15:0];
            4: return m_pix[31:16];
            5: return st[15:0];
            6: return st[31:16];
            7: return m_drop;
            default: return 16'h0000;
        endcase
    endfunction

    // Header timing is tracked as an offset from the edge that accepted FRAME_END.
    always @(posedge clk) begin
        int k;
        cyc++;
        e_dvo = 1'b0;
        e_dtype = '0;
        e_data = '0;
        if (!resetb) begin
            m_in_frame = 0; m_in_hdr = 0; m_en_prev = 0;
            m_fc = '0; m_pix = '0; m_ts = '0; m_stamp = '0; m_drop = '0;
        end else begin
            if (pix_override) m_pix = 32'hFFFF_FFFE;
            if (enable && !m_en_prev) begin
                m_fc = '0; m_pix = '0; m_drop = '0;
            end
            if (!enable) begin
                m_in_frame = 0;
                m_in_hdr = 0;
            end else if (m_in_hdr) begin
                k = int'(cyc - hdr_base);
                e_dvo = 1'b1;
                if (k == 1) e_dtype = HS;
                else if (k == HW + 2) begin
                    e_dtype = HE;
                    m_fc++;
                    m_in_hdr = 0;
                end else begin
                    e_dtype = HD;
                    e_data = hdr_word(k - 2);
                end
                if (dvi && dtypei == FS && m_drop != 16'hFFFF) m_drop++;
            end else if (dvi && (m_in_frame || dtypei == FS)) begin
                e_dvo = 1'b1;
                e_dtype = dtypei;
                e_data = datai;
                if (dtypei == FS) begin
                    m_in_frame = 1;
                    m_pix = '0;
                    m_stamp = m_ts;
                end else if ((dtypei & PM) != 0 && m_pix != 32'hFFFF_FFFF) m_pix++;
                if (dtypei == FE) begin
                    m_in_frame = 0;
                    m_in_hdr = 1;
                    hdr_base = cyc;
                end
            end
            m_en_prev = enable;
            m_ts++;
        end
        e_busy = m_in_frame || m_in_hdr;
        #1;
        check("dvo", {31'd0, dvo}, {31'd0, e_dvo});
        if (e_dvo) begin
            check("dtypeo", {24'd0, dtypeo}, {24'd0, e_dtype});
            check("datao", {16'd0, datao}, {16'd0, e_data});
        end
        check("busy", {31'd0, busy}, {31'd0, e_busy});
        check("dropped_count", {16'd0, dropped_count}, {16'd0, m_drop});
        if (dvo === 1'b1) begin
            if (dtypeo == HS) hdr_idx = 0;
            else if (dtypeo == HD) begin
                if (hdr_idx < HW) hdr_obs[hdr_idx] = datao;
                hdr_idx++;
            end else if (dtypeo == HE) hdr_cnt++;
        end
    end

    task automatic drive(input logic v, input logic [7:0] t, input logic [15:0] d);
        @(negedge clk);
        dvi = v;
        dtypei = t;
        datai = d;
    endtask

    task automatic gap(input int n);
        repeat (n) drive(1'b0, 8'h00, 16'h0000);
    endtask

    task automatic pixel();
        drive(1'b1, {2'($urandom_range(1, 3)), 6'($urandom_range(0, 3))}, 16'($urandom));
    endtask

    task automatic frame(input int npix);
        drive(1'b1, FS, 16'($urandom));
        repeat (npix) pixel();
        drive(1'b1, FE, 16'($urandom));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_dvo", {31'd0, dvo}, 32'd0);
        check("rst_dtypeo", {24'd0, dtypeo}, 32'd0);
        check("rst_datao", {16'd0, datao}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_dropped", {16'd0, dropped_count}, 32'd0);
        resetb = 1'b1;
        enable = 1'b1;
        gap(2);

        frame(4);
        gap(HW + 6);
        check("s1_hdrs", hdr_cnt, 1);
        check("s1_w0", {16'd0, hdr_obs[0]}, 32'h0000_A5C3);
        check("s1_w1", {16'd0, hdr_obs[1]}, 32'd0);
        check("s1_w3", {16'd0, hdr_obs[3]}, 32'd4);
        check("s1_w7", {16'd0, hdr_obs[7]}, 32'd0);

        @(negedge clk) enable = 1'b0;
        @(negedge clk) enable = 1'b1;
        base = hdr_cnt;
        frame(2);
        gap(2);
        frame(3);
        gap(HW + 6);
        frame(1);
        gap(HW + 6);
        check("s2_hdrs", hdr_cnt - base, 2);
        check("s2_dropped", {16'd0, dropped_count}, 32'd1);
        check("s2_w1", {16'd0, hdr_obs[1]}, 32'd1);
        check("s2_w7", {16'd0, hdr_obs[7]}, 32'd1);

        drive(1'b1, FS, 16'h0001);
        repeat (2) pixel();
        drive(1'b1, FS, 16'h0002);
        repeat (3) pixel();
        drive(1'b1, FE, 16'h0003);
        gap(HW + 6);
        check("s3_w3", {16'd0, hdr_obs[3]}, 32'd3);

        base = hdr_cnt;
        frame(2);
        gap(6);
        @(negedge clk) enable = 1'b0;
        @(negedge clk);
        check("s4_beats", hdr_idx, 5);
        check("s4_dvo", {31'd0, dvo}, 32'd0);
        check("s4_busy", {31'd0, busy}, 32'd0);
        gap(HW);
        check("s4_no_end", hdr_cnt - base, 0);
        @(negedge clk) enable = 1'b1;
        frame(2);
        gap(HW + 6);
        check("s4_w1", {16'd0, hdr_obs[1]}, 32'd0);

        drive(1'b1, FS, 16'h0004);
        @(negedge clk);
        dvi = 1'b0;
        force dut.pixel_count_q = 32'hFFFF_FFFE;
        pix_override = 1'b1;
        @(negedge clk);
        release dut.pixel_count_q;
        pix_override = 1'b0;
        repeat (3) pixel();
        drive(1'b1, FE, 16'h0005);
        gap(HW + 6);
        check("s5_w3", {16'd0, hdr_obs[3]}, 32'h0000_FFFF);
        check("s5_w4", {16'd0, hdr_obs[4]}, 32'h0000_FFFF);

        for (int f = 0; f < 40; f++) begin
            int npix;
            npix = $urandom_range(0, 10);
            if ($urandom_range(0, 5) == 0) drive(1'b1, FE, 16'($urandom));
            drive(1'b1, FS, 16'($urandom));
            for (int p = 0; p < npix; p++) begin
                case ($urandom_range(0, 11))
                    0: drive(1'b0, 8'h40, 16'($urandom));
                    1: drive(1'b1, 8'h20, 16'($urandom));
                    2: drive(1'b1, FS, 16'($urandom));
                    3: begin
                        drive(1'b0, 8'h00, 16'h0000);
                        enable = 1'b0;
                        gap($urandom_range(1, 3));
                        enable = 1'b1;
                    end
                    default: pixel();
                endcase
            end
            drive(1'b1, FE, 16'($urandom));
            gap($urandom_range(0, HW + 6));
        end
        gap(HW + 8);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
